program_counter: RTL and testbench



---
 rtl/pio_pkg.sv | 19 +
 rtl/delay_counter.sv | 35 +++
 rtl/program_counter.sv | 125 ++++++++++++
 tb/tb_program_counter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared types and constants for the PIO program counter
package pio_pkg;

  localparam int PC_W            = 5;
  localparam int DLY_W           = 5;
  localparam int WRAP_TOP_LSB    = 12;
  localparam int WRAP_BOTTOM_LSB = 7;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_EXEC     = 2'd1,
    ST_DELAY    = 2'd2
`ifdef PIO_PC_BREAKPOINT_EN
    ,
    ST_HALT     = 2'd3
`endif
  } pcState_t;

endpackage

// File: rtl/delay_counter.sv
// rtl/delay_counter.sv - per-instruction delay down-counter with freeze
module delay_counter
  import pio_pkg::*;
#(
  parameter int DLY_W = pio_pkg::DLY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             freeze,
  input  logic             load,
  input  logic [DLY_W-1:0] loadValue,
  input  logic             decrement,
  output logic [DLY_W-1:0] count,
  output logic             done,
  output logic             busy
);

  // Clear wins over freeze so a restart always drops any pending delay.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (freeze) begin
      count <= count;
    end else if (load) begin
      count <= loadValue;
    end else if (decrement && (count != '0)) begin
      count <= count - DLY_W'(1);
    end
  end

  assign done = (count == DLY_W'(1));
  assign busy = (count != '0);

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PIO instruction sequencer (optional breakpoint via PIO_PC_BREAKPOINT_EN)
module program_counter
  import pio_pkg::*;
#(
  parameter int PC_W  = pio_pkg::PC_W,
  parameter int DLY_W = pio_pkg::DLY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_smEnable,
  input  logic             in_restart,
  input  logic [31:0]      in_smExecCtrl,
  input  logic             in_stall,
  input  logic             in_jmpEnable,
  input  logic [PC_W-1:0]  in_jmpAddr,
  input  logic [DLY_W-1:0] in_delay,
`ifdef PIO_PC_BREAKPOINT_EN
  input  logic             in_bpEnable,
  input  logic [PC_W-1:0]  in_bpAddr,
  input  logic             in_bpResume,
  output logic             out_bpHit,
`endif
  output logic [PC_W-1:0]  out_pc,
  output logic             out_issue,
  output logic             out_delayActive
);

  pcState_t        state;
  logic [PC_W-1:0] pcQ;
  logic [PC_W-1:0] wrapTop;
  logic [PC_W-1:0] wrapBottom;
  logic [PC_W-1:0] nextPc;
  logic [DLY_W-1:0] delayCount;
  logic            delayDone;
  logic            delayBusy;
  logic            delayLoad;
  logic            unusedCtrl;

  assign wrapTop    = in_smExecCtrl[WRAP_TOP_LSB +: PC_W];
  assign wrapBottom = in_smExecCtrl[WRAP_BOTTOM_LSB +: PC_W];
  assign unusedCtrl = ^{in_smExecCtrl[31:WRAP_TOP_LSB+PC_W], in_smExecCtrl[WRAP_BOTTOM_LSB-1:0], delayCount};

  // Redirect priority: taken jump, then wrap, then sequential.
  always_comb begin
    nextPc = pcQ + PC_W'(1);
    if (in_jmpEnable) begin
      nextPc = in_jmpAddr;
    end else if (pcQ == wrapTop) begin
      nextPc = wrapBottom;
    end
  end

  assign delayLoad = (state == ST_EXEC) && !in_stall && (in_delay != '0);

  delay_counter #(.DLY_W(DLY_W)) u_delayCounter (
    .clk       (clk),
    .reset     (reset),
    .clear     (in_restart),
    .freeze    (!in_smEnable),
    .load      (delayLoad),
    .loadValue (in_delay),
    .decrement (state == ST_DELAY),
    .count     (delayCount),
    .done      (delayDone),
    .busy      (delayBusy)
  );

  // State entered whenever EXEC would be entered with a given pc (breakpoint may divert to HALT).
  pcState_t entryPc;
  pcState_t entryNext;
  pcState_t entryBottom;
`ifdef PIO_PC_BREAKPOINT_EN
  assign entryPc     = (in_bpEnable && (pcQ == in_bpAddr))        ? ST_HALT : ST_EXEC;
  assign entryNext   = (in_bpEnable && (nextPc == in_bpAddr))     ? ST_HALT : ST_EXEC;
  assign entryBottom = (in_bpEnable && (wrapBottom == in_bpAddr)) ? ST_HALT : ST_EXEC;
`else
  assign entryPc     = ST_EXEC;
  assign entryNext   = ST_EXEC;
  assign entryBottom = ST_EXEC;
`endif

  // Sequencer FSM and program counter: restart, then disable, then per-state behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_DISABLED;
      pcQ   <= '0;
    end else if (in_restart) begin
      pcQ   <= wrapBottom;
      state <= in_smEnable ? entryBottom : ST_DISABLED;
    end else if (!in_smEnable) begin
      state <= ST_DISABLED;
    end else begin
      case (state)
        ST_DISABLED: state <= delayBusy ? ST_DELAY : entryPc;
        ST_EXEC: begin
          if (!in_stall) begin
            pcQ   <= nextPc;
            state <= (in_delay != '0) ? ST_DELAY : entryNext;
          end
        end
        ST_DELAY: begin
          if (delayDone) begin
            state <= entryPc;
          end
        end
`ifdef PIO_PC_BREAKPOINT_EN
        ST_HALT: begin
          if (in_bpResume) begin
            state <= ST_EXEC;
          end
        end
`endif
        default: state <= ST_DISABLED;
      endcase
    end
  end

  assign out_pc          = pcQ;
  assign out_issue       = (state == ST_EXEC);
  assign out_delayActive = (state == ST_DELAY);
`ifdef PIO_PC_BREAKPOINT_EN
  assign out_bpHit       = (state == ST_HALT);
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        smEnable;
  logic        restart;
  logic [31:0] smExecCtrl;
  logic        stall;
  logic        jmpEnable;
  logic [4:0]  jmpAddr;
  logic [4:0]  delay;
  logic [4:0]  pc;
  logic        issue;
  logic        delayActive;
  logic        bpHitSeen;
`ifdef PIO_PC_BREAKPOINT_EN
  logic        bpEnable;
  logic [4:0]  bpAddr;
  logic        bpResume;
  logic        bpHit;
  assign bpHitSeen = bpHit;
`else
  assign bpHitSeen = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } expEntry_t;
  expEntry_t sbQ[$];

  always #5 clk = ~clk;

  program_counter dut (
    .clk             (clk),
    .reset           (reset),
    .in_smEnable     (smEnable),
    .in_restart      (restart),
    .in_smExecCtrl   (smExecCtrl),
    .in_stall        (stall),
    .in_jmpEnable    (jmpEnable),
    .in_jmpAddr      (jmpAddr),
    .in_delay        (delay),
`ifdef PIO_PC_BREAKPOINT_EN
    .in_bpEnable     (bpEnable),
    .in_bpAddr       (bpAddr),
    .in_bpResume     (bpResume),
    .out_bpHit       (bpHit),
`endif
    .out_pc          (pc),
    .out_issue       (issue),
    .out_delayActive (delayActive)
  );

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got pc=%0d issue=%b dly=%b hit=%b exp pc=%0d issue=%b dly=%b hit=%b",
               tag, got[7:3], got[2], got[1], got[0], exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [31:0] execCtrl(input logic [4:0] top, input logic [4:0] bottom);
    logic [31:0] v;
    v = '0;
    v[16:12] = top;
    v[11:7]  = bottom;
    return v;
  endfunction

  // Push the expectation for the coming edge, clock once, then pop and compare.
  task automatic tick(input int expPc, input logic expIssue, input logic expDly,
                      input logic expHit, input string tag);
    expEntry_t e;
    e.tag = tag;
    e.val = {expPc[4:0], expIssue, expDly, expHit};
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    e = sbQ.pop_front();
    checkVal(e.tag, {pc, issue, delayActive, bpHitSeen}, e.val);
  endtask

  initial begin
    reset = 1'b1; smEnable = 1'b0; restart = 1'b0; smExecCtrl = execCtrl(5'd5, 5'd2);
    stall = 1'b0; jmpEnable = 1'b0; jmpAddr = 5'd0; delay = 5'd0;
`ifdef PIO_PC_BREAKPOINT_EN
    bpEnable = 1'b0; bpAddr = 5'd0; bpResume = 1'b0;
`endif
    @(negedge clk);
    tick(0, 0, 0, 0, "reset");
    reset = 1'b0;
    tick(0, 0, 0, 0, "idle_disabled");

    // sequential run with wrap 5 -> 2
    smEnable = 1'b1;
    tick(0, 1, 0, 0, "seq0");
    tick(1, 1, 0, 0, "seq1");
    tick(2, 1, 0, 0, "seq2");
    tick(3, 1, 0, 0, "seq3");
    tick(4, 1, 0, 0, "seq4");
    tick(5, 1, 0, 0, "seq5");
    tick(2, 1, 0, 0, "seq_wrap");
    tick(3, 1, 0, 0, "seq_wrap3");

    // delay of 3 at pc=3
    delay = 5'd3;
    tick(4, 0, 1, 0, "dly_a");
    delay = 5'd0;
    tick(4, 0, 1, 0, "dly_b");
    tick(4, 0, 1, 0, "dly_c");
    tick(4, 1, 0, 0, "dly_issue");

    // jump from wrapTop does not wrap
    tick(5, 1, 0, 0, "at_top");
    jmpEnable = 1'b1; jmpAddr = 5'd9;
    tick(9, 1, 0, 0, "jmp");
    stall = 1'b1; delay = 5'd7; jmpAddr = 5'd20;
    for (int i = 0; i < 4; i++) tick(9, 1, 0, 0, "stall_hold");
    stall = 1'b0; jmpEnable = 1'b0; delay = 5'd2;
    tick(10, 0, 1, 0, "stall_drop_dly");

    // disable mid-delay with two cycles left, then re-enable
    delay = 5'd0; smEnable = 1'b0;
    for (int i = 0; i < 5; i++) tick(10, 0, 0, 0, "disabled_frozen");
    smEnable = 1'b1;
    tick(10, 0, 1, 0, "reenable_dly1");
    tick(10, 0, 1, 0, "reenable_dly2");
    tick(10, 1, 0, 0, "reenable_issue");

    // restart during delay
    delay = 5'd4;
    tick(11, 0, 1, 0, "pre_restart_dly");
    delay = 5'd0; restart = 1'b1;
    tick(2, 1, 0, 0, "restart");
    restart = 1'b0;
    tick(3, 1, 0, 0, "post_restart");

    // full-range run, then wrapTop moved below pc=31
    smExecCtrl = execCtrl(5'd31, 5'd0);
    for (int p = 4; p <= 31; p++) tick(p, 1, 0, 0, "run_up");
    smExecCtrl = execCtrl(5'd20, 5'd0);
    tick(0, 1, 0, 0, "mod32_wrap");

    // wrapBottom above wrapTop redirects upward
    smExecCtrl = execCtrl(5'd3, 5'd10);
    tick(1, 1, 0, 0, "inv_1");
    tick(2, 1, 0, 0, "inv_2");
    tick(3, 1, 0, 0, "inv_3");
    tick(10, 1, 0, 0, "inv_redirect");
    tick(11, 1, 0, 0, "inv_after");

`ifdef PIO_PC_BREAKPOINT_EN
    smExecCtrl = execCtrl(5'd5, 5'd2);
    bpEnable = 1'b1; bpAddr = 5'd4; restart = 1'b1;
    tick(2, 1, 0, 0, "bp_restart");
    restart = 1'b0;
    tick(3, 1, 0, 0, "bp_pre");
    tick(4, 0, 0, 1, "bp_halt");
    tick(4, 0, 0, 1, "bp_hold");
    bpResume = 1'b1;
    tick(4, 1, 0, 0, "bp_resume_issue");
    bpResume = 1'b0;
    tick(5, 1, 0, 0, "bp_next");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
